// File: rtl/dp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dp_pkg                                                      |
// | Shared opcodes, ALU control codes, FSM states and immediate types    |
// | for the multicycle RV32I-subset datapath.                            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package dp_pkg;

    localparam logic [6:0] OPCODE_R  = 7'b0110011;
    localparam logic [6:0] OPCODE_I  = 7'b0010011;
    localparam logic [6:0] OPCODE_LW = 7'b0000011;
    localparam logic [6:0] OPCODE_S  = 7'b0100011;
    localparam logic [6:0] OPCODE_B  = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2
    } imm_type_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu                                                         |
// | Combinational integer ALU selected by a 4-bit control code.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] y
);

    localparam int SHW = $clog2(WIDTH);

    // Operation select; shifts use only the low log2(WIDTH) bits of b
    always_comb begin
        y = '0;
        case (ctrl)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: y = a << b[SHW-1:0];
            ALU_SRL: y = a >> b[SHW-1:0];
            ALU_SRA: y = $unsigned($signed(a) >>> b[SHW-1:0]);
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath_imm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : imm_gen                                                     |
// | Sign-extended I/S/B immediate extraction from the instruction word.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module imm_gen
    import dp_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_type_t   imm_type,
    output logic [31:0] imm
);

    // Immediate field reassembly per format
    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        case (imm_type)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile                                                     |
// | 32-entry register file, two async read ports, one sync write port.   |
// | x0 reads as zero and ignores writes. Storage is not reset.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module regfile #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] regs [32];

    // Write port; x0 is hardwired so its writes are dropped
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : multicycle_datapath                                         |
// | Multicycle RV32I-subset datapath with IF/ID/EX/MEM/WB control FSM,   |
// | valid-handshake fetch and ready-handshake data memory.               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module multicycle_datapath
    import dp_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC  = 32'h00400000,
    parameter int          DATAWIDTH   = 32,
    parameter int          CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
);

    generate
        if (DATAWIDTH != 32) begin : g_width_check
            $error("multicycle_datapath: only DATAWIDTH=32 is supported");
        end
    endgenerate

    state_t               state, next_state;
    logic [31:0]          ir;
    logic [DATAWIDTH-1:0] reg_a, reg_b, alu_out, mdr;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [4:0]           rd, rs1, rs2;
    logic                 is_r, is_i, is_lw, is_sw, is_br, legal;
    imm_type_t            imm_type;
    logic [31:0]          imm;
    logic [3:0]           alu_ctrl;
    logic [DATAWIDTH-1:0] alu_b, alu_y, rf_rdata1, rf_rdata2, rf_wdata;
    logic                 rf_we, br_taken, mem_misaligned, br_misaligned;
    logic [31:0]          pc_plus4, br_target;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    // SLTU/SLTIU (funct3=011) is outside the supported subset
    assign is_r  = (opcode == OPCODE_R) && (funct3 != 3'b011);
    assign is_i  = (opcode == OPCODE_I) && (funct3 != 3'b011);
    assign is_lw = (opcode == OPCODE_LW) && (funct3 == 3'b010);
    assign is_sw = (opcode == OPCODE_S) && (funct3 == 3'b010);
    assign is_br = (opcode == OPCODE_B) && (funct3[2:1] == 2'b00);
    assign legal = is_r || is_i || is_lw || is_sw || is_br;

    assign imm_type = is_sw ? IMM_S : (is_br ? IMM_B : IMM_I);

    imm_gen u_imm_gen (
        .instr    (ir[31:7]),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // ALU control from funct3/funct7; SUB exists only in R-type, SRA in both
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                3'b000:  alu_ctrl = (is_r && ir[30]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_ctrl = ALU_SLL;
                3'b010:  alu_ctrl = ALU_SLT;
                3'b100:  alu_ctrl = ALU_XOR;
                3'b101:  alu_ctrl = ir[30] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_ctrl = ALU_OR;
                3'b111:  alu_ctrl = ALU_AND;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

    assign alu_b = is_r ? reg_b : imm;

    alu #(.WIDTH(DATAWIDTH)) u_alu (
        .a    (reg_a),
        .b    (alu_b),
        .ctrl (alu_ctrl),
        .y    (alu_y)
    );

    assign rf_we    = (state == S_WB);
    assign rf_wdata = is_lw ? mdr : alu_out;

    regfile #(.WIDTH(DATAWIDTH)) u_regfile (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    assign br_taken       = (reg_a == reg_b) ^ funct3[0];
    assign pc_plus4       = pc + 32'd4;
    assign br_target      = pc + imm;
    assign mem_misaligned = (CHECK_ALIGN != 0) && (alu_y[1:0] != 2'b00);
    assign br_misaligned  = (CHECK_ALIGN != 0) && br_target[1];

    assign imem_addr  = pc;
    assign dmem_addr  = alu_out;
    assign dmem_wdata = reg_b;
    assign trap       = (state == S_TRAP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; fetch request is gated by reset so it drops immediately
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IF: begin
                imem_req = rst_n;
                if (imem_valid) next_state = S_ID;
            end
            S_ID: begin
                next_state = legal ? S_EX : S_TRAP;
            end
            S_EX: begin
                if (is_br) begin
                    if (br_taken && br_misaligned) begin
                        next_state = S_TRAP;
                    end else begin
                        retire     = 1'b1;
                        next_state = S_IF;
                    end
                end else if (is_lw || is_sw) begin
                    next_state = mem_misaligned ? S_TRAP : S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ready) begin
                    if (is_sw) begin
                        retire     = 1'b1;
                        next_state = S_IF;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                retire     = 1'b1;
                next_state = S_IF;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_TRAP;
            end
        endcase
    end

    // Datapath registers; PC moves only on the retire cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= INITIAL_PC;
            ir      <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            if ((state == S_IF) && imem_valid) ir <= imem_rdata;
            if (state == S_ID) begin
                reg_a <= rf_rdata1;
                reg_b <= rf_rdata2;
            end
            if (state == S_EX) alu_out <= alu_y;
            if ((state == S_MEM) && dmem_ready && is_lw) mdr <= dmem_rdata;
            if (retire) pc <= ((state == S_EX) && br_taken) ? br_target : pc_plus4;
        end
    end

endmodule
`default_nettype wire
